fp_adder_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It generalises the combinational single-precision adder: configurable exponent and mantissa widths, signed operands, subtraction, round-to-nearest-even, special-value handling, and ALU-style NZCV flags. It sits beside the integer ALU in the execute stage and can be stalled by downstream back-pressure.

---
 rtl/fp_adder_pipe_if.sv | 28 ++
 rtl/fp_adder_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point adder.
// The slave side is the adder; the master side is the execute-stage driver.
interface fp_adder_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   ALUFlags;

  modport master (
    output in_valid, srcA, srcB, op, out_ready,
    input  in_ready, out_valid, result, ALUFlags
  );

  modport slave (
    input  in_valid, srcA, srcB, op, out_ready,
    output in_ready, out_valid, result, ALUFlags
  );
endinterface

// File: rtl/fp_adder_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: align, add/sub, normalise/round/pack.
// Denormals read as zero, round-to-nearest-even, NZCV flags, stallable by out_ready.
module fp_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            reset,
  fp_adder_pipe_if.slave bus
);
  localparam int W   = EXP_W + MAN_W + 1;
  localparam int XW  = MAN_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic s1_en, s2_en, s3_en;

  logic             s1_valid_q, s1_nan_q, s1_inf_q, s1_inf_sign_q;
  logic             s1_sign_q, s1_sub_q, s1_negzero_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [XW-1:0]    s1_max_q, s1_min_q;

  logic             s2_valid_q, s2_nan_q, s2_inf_q, s2_inf_sign_q;
  logic             s2_sign_q, s2_negzero_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [XW:0]      s2_sum_q;

  logic             s3_valid_q;
  logic [W-1:0]     result_q;
  logic [3:0]       flags_q;

  assign s3_en        = !s3_valid_q || bus.out_ready;
  assign s2_en        = !s2_valid_q || s3_en;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en;
  assign bus.out_valid = s3_valid_q;
  assign bus.result    = result_q;
  assign bus.ALUFlags  = flags_q;

  // ---------------- S1: decode, order by magnitude, align ----------------
  logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge;
  logic [EXP_W-1:0] ea, eb, diff, max_e;
  logic [MAN_W-1:0] ma, mb;
  logic [MAN_W:0]   fa, fb, max_f, min_f;
  logic             max_s;
  logic [2*XW-1:0]  wide;
  int               sh;
  logic [XW-1:0]    min_x_d;

  assign sa     = bus.srcA[W-1];
  assign sb     = bus.srcB[W-1] ^ bus.op;
  assign ea     = bus.srcA[W-2 -: EXP_W];
  assign eb     = bus.srcB[W-2 -: EXP_W];
  assign ma     = bus.srcA[MAN_W-1:0];
  assign mb     = bus.srcB[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign fa     = a_zero ? '0 : {1'b1, ma};
  assign fb     = b_zero ? '0 : {1'b1, mb};
  assign a_ge   = {ea, fa} >= {eb, fb};

  always_comb begin
    if (a_ge) begin
      max_e = ea; max_f = fa; max_s = sa; min_f = fb; diff = ea - eb;
    end else begin
      max_e = eb; max_f = fb; max_s = sb; min_f = fa; diff = eb - ea;
    end
    // Lower half of the double-width shift collects everything lost past sticky.
    sh      = (int'(diff) >= XW) ? XW : int'(diff);
    wide    = {min_f, 3'b000, {XW{1'b0}}} >> sh;
    min_x_d = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
  end

  // ---------------- S2: magnitude add/subtract ----------------
  logic [XW:0] sum_d;
  assign sum_d = s1_sub_q ? ({1'b0, s1_max_q} - {1'b0, s1_min_q})
                          : ({1'b0, s1_max_q} + {1'b0, s1_min_q});

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]   lzc;
  logic [XW-1:0]    norm;
  logic [EW2-1:0]   exp_n, exp_r;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic             rnd_up, inexact, flush, ovf;
  logic [W-1:0]     result_d;
  logic [3:0]       flags_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < XW; i++) begin
      if (s2_sum_q[i]) lzc = LZW'(XW - 1 - i);
    end
    if (s2_sum_q[XW]) begin
      norm  = {s2_sum_q[XW:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = EW2'(s2_exp_q) + EW2'(1);
    end else begin
      norm  = s2_sum_q[XW-1:0] << lzc;
      exp_n = EW2'(s2_exp_q) - EW2'(lzc);
    end
    mant    = norm[XW-1:3];
    inexact = |norm[2:0];
    rnd_up  = norm[2] & (norm[1] | norm[0] | mant[0]);
    mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
    exp_r   = exp_n + EW2'(mant_r[MAN_W+1]);
    frac    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    flush   = exp_n[EW2-1] || (exp_n == '0);
    ovf     = exp_r >= EW2'(EXP_ONES);

    if (s2_nan_q) begin
      result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d  = 4'b0001;
    end else if (s2_inf_q) begin
      result_d = {s2_inf_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = {s2_inf_sign_q, 3'b000};
    end else if (s2_sum_q == '0) begin
      result_d = {s2_negzero_q, {(W-1){1'b0}}};
      flags_d  = {s2_negzero_q, 3'b100};
    end else if (flush) begin
      result_d = '0;
      flags_d  = 4'b0110;
    end else if (ovf) begin
      result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = {s2_sign_q, 1'b0, inexact, 1'b1};
    end else begin
      result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac};
      flags_d  = {s2_sign_q, 1'b0, inexact, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_nan_q      <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
          s1_inf_q      <= a_inf || b_inf;
          s1_inf_sign_q <= a_inf ? sa : sb;
          s1_sign_q     <= max_s;
          s1_sub_q      <= sa ^ sb;
          s1_negzero_q  <= a_zero && b_zero && sa && sb;
          s1_exp_q      <= max_e;
          s1_max_q      <= {max_f, 3'b000};
          s1_min_q      <= min_x_d;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_nan_q      <= s1_nan_q;
          s2_inf_q      <= s1_inf_q;
          s2_inf_sign_q <= s1_inf_sign_q;
          s2_sign_q     <= s1_sign_q;
          s2_negzero_q  <= s1_negzero_q;
          s2_exp_q      <= s1_exp_q;
          s2_sum_q      <= sum_d;
        end
      end
      if (s3_en) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
      end
    end
  end
endmodule
